// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run/step/halt sequencer for a small core. It accepts host commands, gates
//   the core run enable, and counts retired instructions. It stops the core on
//   a step-count expiry, a breakpoint match, a PC overflow, a host halt or an
//   illegal command. A RESET command pulses a clear to the core for CLR_CYC
//   cycles.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   HALT  | core stopped, waiting for a command
//   RUN   | core free-running (optionally watching for a breakpoint)
//   STEP  | core running until the step counter expires
//   CLEAR | clr_o asserted for CLR_CYC cycles, commands not accepted
//
// Ports
//   clk_i        clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   cmd_valid_i  host command strobe
//   cmd_ready_o  command accept (low only in CLEAR)
//   cmd_op_i     0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 RESET, 5 RUN_BP, 6-7 illegal
//   cmd_arg_i    step count for STEP (0 behaves as 1)
//   bp_addr_i    breakpoint PC, captured when RUN_BP starts a run
//   pc_i         current core PC
//   retire_i     one pulse per retired instruction
//   pc_ov_i      PC out-of-range flag
//   run_en_o     core run enable
//   clr_o        core clear
//   state_o      0 HALT, 1 RUN, 2 STEP, 3 CLEAR
//   done_o       one-cycle pulse on each entry to HALT
//   cause_o      last halt cause: 0 HOST, 1 STEP, 2 BP, 3 OV, 4 CLR, 5 ILLEGAL
//   cyc_cnt_o    saturating retire count since the last RESET command
module proc_run_ctrl #(
  parameter int unsigned CLR_CYC = 4,
  parameter int unsigned STEP_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [STEP_W-1:0] cmd_arg_i,
  input  logic [31:0]       bp_addr_i,
  input  logic [31:0]       pc_i,
  input  logic              retire_i,
  input  logic              pc_ov_i,
  output logic              run_en_o,
  output logic              clr_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [2:0]        cause_o,
  output logic [31:0]       cyc_cnt_o
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_HALT   = 3'd3;
  localparam logic [2:0] OP_RESET  = 3'd4;
  localparam logic [2:0] OP_RUN_BP = 3'd5;

  localparam logic [2:0] CAUSE_HOST    = 3'd0;
  localparam logic [2:0] CAUSE_STEP    = 3'd1;
  localparam logic [2:0] CAUSE_BP      = 3'd2;
  localparam logic [2:0] CAUSE_OV      = 3'd3;
  localparam logic [2:0] CAUSE_CLR     = 3'd4;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd5;

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [7:0]        CLR_LAST = 8'(CLR_CYC - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [7:0]          clr_cnt_q, clr_cnt_d;
  logic [31:0]         bp_addr_q, bp_addr_d;
  logic                bp_en_q, bp_en_d;
  logic [2:0]          cause_q, cause_d;
  logic [31:0]         cyc_cnt_q;
  logic                run_en_q, clr_q, done_q;

  logic                cmd_acc;
  logic                retire_acc;
  logic                op_illegal;
  logic                bp_hit;
  logic                step_last;
  logic                halt_evt;
  logic [2:0]          halt_cause;
  logic                cnt_zero;

  assign cmd_ready_o = (state_q != ST_CLEAR);
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;
  assign retire_acc  = retire_i & run_en_q;
  assign op_illegal  = cmd_op_i[2] & cmd_op_i[1];
  assign bp_hit      = bp_en_q & retire_acc & (pc_i == bp_addr_q);
  assign step_last   = (state_q == ST_STEP) & retire_acc & (step_cnt_q == STEP_ONE);

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    bp_addr_d  = bp_addr_q;
    bp_en_d    = bp_en_q;
    cause_d    = cause_q;
    halt_evt   = 1'b0;
    halt_cause = CAUSE_HOST;
    cnt_zero   = 1'b0;

    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == 8'd0) begin
        halt_evt   = 1'b1;
        halt_cause = CAUSE_CLR;
      end else begin
        clr_cnt_d = clr_cnt_q - 8'd1;
      end
    end else if (cmd_acc && cmd_op_i == OP_RESET) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = CLR_LAST;
      cnt_zero  = 1'b1;
    end else if (cmd_acc && op_illegal) begin
      halt_evt   = 1'b1;
      halt_cause = CAUSE_ILLEGAL;
    end else if (cmd_acc && cmd_op_i == OP_HALT) begin
      halt_evt   = 1'b1;
      halt_cause = CAUSE_HOST;
    end else if (state_q == ST_HALT) begin
      // Run commands only take effect from HALT; while running they are no-ops.
      if (cmd_acc) begin
        case (cmd_op_i)
          OP_RUN: begin
            state_d = ST_RUN;
            bp_en_d = 1'b0;
          end
          OP_RUN_BP: begin
            state_d   = ST_RUN;
            bp_en_d   = 1'b1;
            bp_addr_d = bp_addr_i;
          end
          OP_STEP: begin
            state_d    = ST_STEP;
            bp_en_d    = 1'b0;
            step_cnt_d = (cmd_arg_i == '0) ? STEP_ONE : cmd_arg_i;
          end
          default: ;
        endcase
      end
    end else begin
      if (pc_ov_i) begin
        halt_evt   = 1'b1;
        halt_cause = CAUSE_OV;
      end else if (bp_hit) begin
        halt_evt   = 1'b1;
        halt_cause = CAUSE_BP;
      end else if (step_last) begin
        halt_evt   = 1'b1;
        halt_cause = CAUSE_STEP;
      end else if (state_q == ST_STEP && retire_acc) begin
        step_cnt_d = step_cnt_q - STEP_ONE;
      end
    end

    if (halt_evt) begin
      state_d = ST_HALT;
      cause_d = halt_cause;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_HALT;
      step_cnt_q <= '0;
      clr_cnt_q  <= '0;
      bp_addr_q  <= '0;
      bp_en_q    <= 1'b0;
      cause_q    <= CAUSE_HOST;
      cyc_cnt_q  <= '0;
      run_en_q   <= 1'b0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      bp_addr_q  <= bp_addr_d;
      bp_en_q    <= bp_en_d;
      cause_q    <= cause_d;
      run_en_q   <= (state_d == ST_RUN) || (state_d == ST_STEP);
      clr_q      <= (state_d == ST_CLEAR);
      done_q     <= halt_evt;
      // Clearing on RESET wins over a retire landing in the same cycle.
      if (cnt_zero) begin
        cyc_cnt_q <= '0;
      end else if (retire_acc && cyc_cnt_q != 32'hFFFF_FFFF) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
    end
  end

  assign run_en_o  = run_en_q;
  assign clr_o     = clr_q;
  assign state_o   = state_q;
  assign done_o    = done_q;
  assign cause_o   = cause_q;
  assign cyc_cnt_o = cyc_cnt_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
module tb_proc_run_ctrl;

  localparam int CLR_CYC = 4;
  localparam int STEP_W  = 16;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [2:0]        cmd_op_i;
  logic [STEP_W-1:0] cmd_arg_i;
  logic [31:0]       bp_addr_i;
  logic [31:0]       pc_i;
  logic              retire_i;
  logic              pc_ov_i;
  logic              run_en_o;
  logic              clr_o;
  logic [1:0]        state_o;
  logic              done_o;
  logic [2:0]        cause_o;
  logic [31:0]       cyc_cnt_o;

  proc_run_ctrl #(.CLR_CYC(CLR_CYC), .STEP_W(STEP_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i), .bp_addr_i(bp_addr_i),
    .pc_i(pc_i), .retire_i(retire_i), .pc_ov_i(pc_ov_i),
    .run_en_o(run_en_o), .clr_o(clr_o), .state_o(state_o),
    .done_o(done_o), .cause_o(cause_o), .cyc_cnt_o(cyc_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0 halted, 1 running, 2 stepping, 3 clearing.
  int          m_mode = 0;
  int unsigned m_steps = 0;
  int          m_clr_left = 0;
  logic [31:0] m_bp = '0;
  bit          m_bp_on = 0;
  logic [31:0] m_cnt = '0;
  int          m_cause = 0;
  bit          m_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  nxt;
    bit  stop;
    int  why;
    bit  core_on;
    if (!rst_n) begin
      m_mode = 0; m_steps = 0; m_clr_left = 0; m_bp = '0; m_bp_on = 0;
      m_cnt = '0; m_cause = 0; m_done = 0;
      return;
    end
    core_on = (m_mode == 1 || m_mode == 2);
    nxt = m_mode; stop = 0; why = 0;
    if (m_mode == 3) begin
      m_clr_left--;
      if (m_clr_left == 0) begin stop = 1; why = 4; end
    end else if (cmd_valid_i && cmd_op_i == 4) begin
      nxt = 3; m_clr_left = CLR_CYC;
    end else if (cmd_valid_i && cmd_op_i >= 6) begin
      stop = 1; why = 5;
    end else if (cmd_valid_i && cmd_op_i == 3) begin
      stop = 1; why = 0;
    end else if (m_mode == 0) begin
      if (cmd_valid_i && cmd_op_i == 1) begin nxt = 1; m_bp_on = 0; end
      if (cmd_valid_i && cmd_op_i == 5) begin nxt = 1; m_bp_on = 1; m_bp = bp_addr_i; end
      if (cmd_valid_i && cmd_op_i == 2) begin
        nxt = 2; m_bp_on = 0;
        m_steps = (cmd_arg_i == 0) ? 1 : int'(cmd_arg_i);
      end
    end else begin
      if (pc_ov_i) begin stop = 1; why = 3; end
      else if (retire_i && m_bp_on && pc_i == m_bp) begin stop = 1; why = 2; end
      else if (m_mode == 2 && retire_i) begin
        if (m_steps == 1) begin stop = 1; why = 1; end
        else m_steps--;
      end
    end
    if (nxt == 3 && m_mode != 3) m_cnt = '0;
    else if (retire_i && core_on && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (stop) begin nxt = 0; m_cause = why; end
    m_done = stop;
    m_mode = nxt;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    chk("state", 32'(state_o), 32'(m_mode));
    chk("run_en", 32'(run_en_o), 32'(m_mode == 1 || m_mode == 2));
    chk("clr", 32'(clr_o), 32'(m_mode == 3));
    chk("ready", 32'(cmd_ready_o), 32'(m_mode != 3));
    chk("done", 32'(done_o), 32'(m_done));
    chk("cause", 32'(cause_o), 32'(m_cause));
    chk("cyc_cnt", cyc_cnt_o, m_cnt);
  endtask

  task automatic idle();
    cmd_valid_i = 0; cmd_op_i = 0; cmd_arg_i = 0;
    retire_i = 0; pc_ov_i = 0;
  endtask

  task automatic send(input logic [2:0] op, input logic [STEP_W-1:0] arg, input logic [31:0] bp);
    cmd_valid_i = 1; cmd_op_i = op; cmd_arg_i = arg; bp_addr_i = bp;
    cycle();
    cmd_valid_i = 0; cmd_op_i = 0;
  endtask

  initial begin
    bit seen;
    int nret;
    int nclr;
    int nbusy;
    logic [31:0] pc;

    rst_n = 0; bp_addr_i = '0; pc_i = '0;
    idle();
    #1;
    cycle(); cycle();
    rst_n = 1;
    cycle();
    chk("reset_ready", 32'(cmd_ready_o), 32'd1);
    chk("reset_cnt", cyc_cnt_o, 32'd0);

    // STEP 3, retire every second cycle
    send(3'd2, 16'd3, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      retire_i = i[0];
      cycle();
      if (done_o) seen = 1;
    end
    retire_i = 0;
    chk("step3_done", 32'(seen), 32'd1);
    chk("step3_cause", 32'(cause_o), 32'd1);
    chk("step3_cnt", cyc_cnt_o, 32'd3);
    chk("step3_runen", 32'(run_en_o), 32'd0);

    // RUN_BP at 0x10 with PC advancing by 4 per retire
    send(3'd5, '0, 32'h10);
    seen = 0; nret = 0; pc = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      retire_i = 1; pc_i = pc;
      cycle();
      nret++; pc = pc + 4;
      if (done_o) seen = 1;
    end
    retire_i = 0;
    chk("bp_retires", 32'(nret), 32'd5);
    chk("bp_cause", 32'(cause_o), 32'd2);

    // Host HALT in the same cycle as PC overflow
    send(3'd1, '0, '0);
    cycle();
    pc_ov_i = 1;
    send(3'd3, '0, '0);
    pc_ov_i = 0;
    chk("halt_ov_done", 32'(done_o), 32'd1);
    chk("halt_ov_cause", 32'(cause_o), 32'd0);
    cycle();
    chk("halt_ov_single", 32'(done_o), 32'd0);

    // RESET: clear window length
    send(3'd4, '0, '0);
    nclr = 0; nbusy = 0; seen = 0;
    if (clr_o) nclr++;
    if (!cmd_ready_o) nbusy++;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (clr_o) nclr++;
      if (!cmd_ready_o) nbusy++;
      if (done_o) seen = 1;
    end
    chk("clr_cycles", 32'(nclr), 32'd4);
    chk("clr_busy", 32'(nbusy), 32'd4);
    chk("clr_done", 32'(seen), 32'd1);
    chk("clr_cnt", cyc_cnt_o, 32'd0);
    chk("clr_cause", 32'(cause_o), 32'd4);

    // STEP with arg 0 behaves as a single step
    send(3'd2, 16'd0, '0);
    seen = 0; nret = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      retire_i = 1;
      cycle();
      nret++;
      if (done_o) seen = 1;
    end
    retire_i = 0;
    chk("step0_retires", 32'(nret), 32'd1);
    chk("step0_cause", 32'(cause_o), 32'd1);

    // Illegal op while running
    send(3'd1, '0, '0);
    cycle();
    send(3'd7, '0, '0);
    chk("illegal_cause", 32'(cause_o), 32'd5);
    chk("illegal_done", 32'(done_o), 32'd1);

    // Reset pulse mid-STEP
    send(3'd2, 16'd10, '0);
    retire_i = 1; cycle(); cycle();
    retire_i = 0;
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_runen", 32'(run_en_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", cyc_cnt_o, 32'd0);
    chk("rst_cause", 32'(cause_o), 32'd0);
    cycle();
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_done_after", 32'(done_o), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      cmd_valid_i = ($urandom_range(0, 3) == 0);
      cmd_op_i    = 3'($urandom_range(0, 7));
      if (cmd_op_i == 3'd4 && $urandom_range(0, 2) != 0) cmd_op_i = 3'd2;
      cmd_arg_i   = STEP_W'($urandom_range(0, 5));
      bp_addr_i   = 32'($urandom_range(0, 7) * 4);
      pc_i        = 32'($urandom_range(0, 7) * 4);
      retire_i    = $urandom_range(0, 1) == 1;
      pc_ov_i     = ($urandom_range(0, 29) == 0);
      cycle();
    end
    rst_n = 1;
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
